// File: rtl/pwm_modulator.sv
// pwm_modulator: turns each signed Q0.N_FRAC sample into one PWM period and requests the next one.
// Optional build macro PWM_CENTER_ALIGNED_EN selects up/down (centre-aligned) period counting.
module pwm_modulator #(
  parameter int N_FRAC     = 7,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic [N_FRAC:0]       data_i,
  input  logic                  data_valid_strobe_i,
  output logic                  get_next_data_strobe_o,
  output logic                  pwm_o,
  output logic                  underrun_o
);

  localparam int W = N_FRAC + 1;
  localparam logic [W-1:0]          CNT_ZERO   = {W{1'b0}};
  localparam logic [W-1:0]          CNT_ONE    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]          CNT_MAX    = {W{1'b1}};
  localparam logic [W-1:0]          MIDSCALE   = {1'b1, {N_FRAC{1'b0}}};
  localparam logic [PRESCALE_W-1:0] PRESC_ZERO = {PRESCALE_W{1'b0}};
  localparam logic [PRESCALE_W-1:0] PRESC_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic [PRESCALE_W-1:0] r_presc;
  logic [W-1:0]          r_cnt;
  logic [W-1:0]          r_duty_pending;
  logic [W-1:0]          r_duty_active;
  logic                  r_running;
  logic                  r_pending_valid;
  logic                  r_pwm;
  logic                  r_strobe;
  logic                  r_underrun;

  logic                  w_active;
  logic                  w_start;
  logic                  w_tick;
  logic                  w_boundary;
  logic                  w_pwm_next;
  logic [W-1:0]          w_cnt_next;
  logic [W-1:0]          w_sample_duty;
  logic [PRESCALE_W-1:0] w_presc_next;

`ifdef PWM_CENTER_ALIGNED_EN
  logic                  r_down;
  logic                  w_down_next;
`endif

  // Run qualification, tick generation and offset-binary duty mapping.
  always_comb begin
    w_active      = r_running & enable_i;
    w_start       = enable_i & ~r_running;
    w_tick        = w_active & (r_presc >= prescale_i);
    w_sample_duty = {~data_i[W-1], data_i[W-2:0]};
    w_pwm_next    = w_active & (r_cnt < r_duty_active);
  end

  // Prescaler and period counter next state; boundary is the last tick of a period.
  always_comb begin
    w_presc_next = r_presc;
    w_cnt_next   = r_cnt;
    w_boundary   = 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
    w_down_next  = r_down;
`endif
    if (!w_active) begin
      w_presc_next = PRESC_ZERO;
      w_cnt_next   = CNT_ZERO;
`ifdef PWM_CENTER_ALIGNED_EN
      w_down_next  = 1'b0;
`endif
    end else if (w_tick) begin
      w_presc_next = PRESC_ZERO;
`ifdef PWM_CENTER_ALIGNED_EN
      if (r_down) begin
        if (r_cnt == CNT_ZERO) begin
          w_boundary  = 1'b1;
          w_down_next = 1'b0;
          w_cnt_next  = CNT_ONE;
        end else begin
          w_cnt_next  = r_cnt - CNT_ONE;
        end
      end else begin
        if (r_cnt == CNT_MAX) begin
          w_down_next = 1'b1;
          w_cnt_next  = CNT_MAX - CNT_ONE;
        end else begin
          w_cnt_next  = r_cnt + CNT_ONE;
        end
      end
`else
      w_boundary = (r_cnt == CNT_MAX);
      w_cnt_next = r_cnt + CNT_ONE;
`endif
    end else begin
      w_presc_next = r_presc + PRESC_ONE;
    end
  end

  // State registers; the boundary consumes only the registered pending sample.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_presc         <= PRESC_ZERO;
      r_cnt           <= CNT_ZERO;
      r_running       <= 1'b0;
      r_pending_valid <= 1'b0;
      r_duty_pending  <= MIDSCALE;
      r_duty_active   <= MIDSCALE;
      r_pwm           <= 1'b0;
      r_strobe        <= 1'b0;
      r_underrun      <= 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
      r_down          <= 1'b0;
`endif
    end else begin
      r_presc   <= w_presc_next;
      r_cnt     <= w_cnt_next;
      r_running <= enable_i;
      r_pwm     <= w_pwm_next;
      r_strobe  <= w_start | w_boundary;
`ifdef PWM_CENTER_ALIGNED_EN
      r_down    <= w_down_next;
`endif
      if (w_boundary && !r_pending_valid) begin
        r_underrun <= 1'b1;
      end
      if (w_boundary && r_pending_valid) begin
        r_duty_active <= r_duty_pending;
      end
      // A sample arriving on the boundary itself is kept for the next boundary.
      if (data_valid_strobe_i) begin
        r_duty_pending  <= w_sample_duty;
        r_pending_valid <= 1'b1;
      end else if (w_boundary) begin
        r_pending_valid <= 1'b0;
      end
    end
  end

  assign get_next_data_strobe_o = r_strobe;
  assign pwm_o                  = r_pwm;
  assign underrun_o             = r_underrun;

endmodule

// File: tb/tb_pwm_modulator.sv
// Self-checking bench for pwm_modulator: table-driven duty/prescale vectors with a
// per-period scoreboard, plus underrun, collision, disable and async-reset sequences.
`timescale 1ns/1ps
module tb_pwm_modulator;

  localparam int N_FRAC     = 7;
  localparam int PRESCALE_W = 8;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       enable_i;
  logic [7:0] prescale_i;
  logic [7:0] data_i;
  logic       data_valid_strobe_i;
  logic       get_next_data_strobe_o;
  logic       pwm_o;
  logic       underrun_o;

  always #5 clk_i = ~clk_i;

  pwm_modulator #(.N_FRAC(N_FRAC), .PRESCALE_W(PRESCALE_W)) dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .enable_i               (enable_i),
    .prescale_i             (prescale_i),
    .data_i                 (data_i),
    .data_valid_strobe_i    (data_valid_strobe_i),
    .get_next_data_strobe_o (get_next_data_strobe_o),
    .pwm_o                  (pwm_o),
    .underrun_o             (underrun_o)
  );

  typedef struct { logic [7:0] data; logic [7:0] presc; int exp_hi; int exp_clks; } vec_t;
  typedef struct { int hi; int clks; } win_t;

  int         checks   = 0;
  int         failures = 0;
  win_t       exp_q[$];
  logic       und_q[$];
  int         resp_mode[8];   // 0: answer next cycle, 1: ignore, 2: answer on the boundary tick
  logic [7:0] resp_data[8];
  int         last_hi;
  int         last_clks;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int duty_of(input logic [7:0] d);
    return int'($signed(d)) + 128;
  endfunction

  task automatic do_reset();
    rst_i = 1'b1;
    enable_i = 1'b0;
    data_valid_strobe_i = 1'b0;
    data_i = 8'h00;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  // Reset, enable, and answer requests per resp_mode; every closed period is scored.
  task automatic run(input string tag, input logic [7:0] presc, input int n_win);
    int win_len, budget, cyc, req, closed, hi, clks, mode, cur_duty;
    bit win_open, ans_pend, late_pend, just_req, m_pv, sticky, pv_b;
    logic [7:0] ans_data, late_data, m_pd, pd_b, d;
    win_t w;
    logic eu;
    win_len = 256 * (int'(presc) + 1);
    budget = (n_win + 2) * win_len + 64;
    cyc = 0; req = 0; closed = 0; hi = 0; clks = 0; cur_duty = 128;
    win_open = 1'b0; ans_pend = 1'b0; late_pend = 1'b0; m_pv = 1'b0; sticky = 1'b0;
    ans_data = 8'h00; late_data = 8'h00; m_pd = 8'h00;
    do_reset();
    exp_q.delete();
    und_q.delete();
    prescale_i = presc;
    exp_q.push_back('{cur_duty * (int'(presc) + 1), win_len});
    enable_i = 1'b1;
    while (closed < n_win && cyc < budget) begin
      @(negedge clk_i);
      cyc++;
      just_req = 1'b0;
      if (cyc == 1) check($sformatf("%s prime strobe", tag), get_next_data_strobe_o, 1);
      if (win_open) begin
        hi += int'(pwm_o);
        clks++;
      end
      if (get_next_data_strobe_o === 1'b1) begin
        if (win_open) begin
          w = exp_q.pop_front();
          eu = und_q.pop_front();
          check($sformatf("%s win%0d high", tag, closed), hi, w.hi);
          check($sformatf("%s win%0d clocks", tag, closed), clks, w.clks);
          check($sformatf("%s win%0d underrun", tag, closed), underrun_o, eu);
          last_hi = hi;
          last_clks = clks;
          closed++;
        end
        win_open = 1'b1;
        hi = 0;
        clks = 0;
        just_req = 1'b1;
        mode = resp_mode[req % 8];
        d = resp_data[req % 8];
        if (mode == 0) begin
          ans_pend = 1'b1; ans_data = d; pv_b = 1'b1; pd_b = d;
        end else begin
          pv_b = m_pv; pd_b = m_pd;
          if (mode == 2) begin
            late_pend = 1'b1; late_data = d;
          end
        end
        if (pv_b) cur_duty = duty_of(pd_b);
        else sticky = 1'b1;
        und_q.push_back(sticky);
        exp_q.push_back('{cur_duty * (int'(presc) + 1), win_len});
        m_pv = (mode == 2);
        m_pd = d;
        req++;
      end
      data_valid_strobe_i = 1'b0;
      if (ans_pend && !just_req) begin
        data_valid_strobe_i = 1'b1; data_i = ans_data; ans_pend = 1'b0;
      end else if (late_pend && win_open && clks == win_len - 1) begin
        data_valid_strobe_i = 1'b1; data_i = late_data; late_pend = 1'b0;
      end
    end
    check($sformatf("%s periods completed", tag), closed, n_win);
    data_valid_strobe_i = 1'b0;
  endtask

  initial begin
    vec_t vecs[6];
    int   n, found;
    vecs[0] = '{8'h00, 8'd0, 128, 256};
    vecs[1] = '{8'h80, 8'd0,   0, 256};
    vecs[2] = '{8'h7F, 8'd0, 255, 256};
    vecs[3] = '{8'h40, 8'd0, 192, 256};
    vecs[4] = '{8'h00, 8'd3, 512, 1024};
    vecs[5] = '{8'hC0, 8'd1, 128, 512};
    last_hi = 0; last_clks = 0;
    prescale_i = 8'd0;
    data_i = 8'h00;
    data_valid_strobe_i = 1'b0;
    enable_i = 1'b0;
    rst_i = 1'b1;
    #3;
    check("reset pwm", pwm_o, 0);
    check("reset strobe", get_next_data_strobe_o, 0);
    check("reset underrun", underrun_o, 0);

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 8; k++) begin
        resp_mode[k] = 0;
        resp_data[k] = vecs[i].data;
      end
      run($sformatf("vec%0d", i), vecs[i].presc, 3);
      check($sformatf("vec%0d table high", i), last_hi, vecs[i].exp_hi);
      check($sformatf("vec%0d table clocks", i), last_clks, vecs[i].exp_clks);
    end

    // Underrun: second request ignored, duty 160 must repeat and the flag must stick.
    for (int k = 0; k < 8; k++) begin
      resp_mode[k] = 0;
      resp_data[k] = 8'h20;
    end
    resp_mode[1] = 1;
    resp_data[3] = 8'h00;
    run("underrun", 8'd0, 5);

    // Collision: sample lands on the boundary tick with nothing pending.
    for (int k = 0; k < 8; k++) begin
      resp_mode[k] = 0;
      resp_data[k] = 8'h00;
    end
    resp_mode[1] = 2;
    resp_data[1] = 8'h40;
    resp_mode[2] = 1;
    run("collision", 8'd0, 5);

    // Disable mid-period while pwm is high, then re-enable.
    found = 0;
    for (int c = 0; c < 600 && found == 0; c++) begin
      @(negedge clk_i);
      if (pwm_o === 1'b1 && get_next_data_strobe_o === 1'b0) found = 1;
    end
    check("disable found high", found, 1);
    enable_i = 1'b0;
    @(negedge clk_i);
    check("disable pwm", pwm_o, 0);
    n = 0;
    for (int c = 0; c < 6; c++) begin
      if (get_next_data_strobe_o !== 1'b0) n++;
      @(negedge clk_i);
    end
    check("disable strobes", n, 0);
    enable_i = 1'b1;
    @(negedge clk_i);
    check("reenable prime", get_next_data_strobe_o, 1);
    @(negedge clk_i);
    check("reenable prime width", get_next_data_strobe_o, 0);

    // Asynchronous reset mid-period with pwm high and underrun set.
    found = 0;
    for (int c = 0; c < 600 && found == 0; c++) begin
      @(negedge clk_i);
      if (pwm_o === 1'b1) found = 1;
    end
    check("rst found high", found, 1);
    check("rst underrun before", underrun_o, 1);
    #2 rst_i = 1'b1;
    enable_i = 1'b0;
    #1;
    check("async rst pwm", pwm_o, 0);
    check("async rst underrun", underrun_o, 0);
    check("async rst strobe", get_next_data_strobe_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      if (get_next_data_strobe_o !== 1'b0) n++;
    end
    check("post rst strobes", n, 0);
    enable_i = 1'b1;
    @(negedge clk_i);
    check("post rst prime", get_next_data_strobe_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
